// File: rtl/bean_pkg.sv
// Shared BEAN-1 memory-port types: access-size codes, arbiter states, port ownership.
// Pure declarations, no logic.
package bean_pkg;

    localparam logic [1:0] MODE_BYTE = 2'b00;
    localparam logic [1:0] MODE_HALF = 2'b01;
    localparam logic [1:0] MODE_WORD = 2'b10;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_DONE   = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

    // Encoding 11 is handled as a word access everywhere.
    function automatic logic [1:0] norm_mode(input logic [1:0] mode);
        return (mode == 2'b11) ? MODE_WORD : mode;
    endfunction

    function automatic logic misaligned(input logic [1:0] mode, input logic [1:0] addr_lo);
        logic [1:0] m;
        m = norm_mode(mode);
        return ((m == MODE_HALF) && addr_lo[0]) || ((m == MODE_WORD) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the shared BEAN-1 memory port.
// slave = arbiter side, master = requesters plus memory.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_done;

    logic              ls_req;
    logic              ls_we;
    logic [1:0]        ls_mode;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic [DATA_W-1:0] ls_rdata;
    logic              ls_done;
    logic              ls_err;

    logic [ADDR_W-1:0] mem_addrs;
    logic              mem_WE;
    logic [1:0]        mem_MODE;
    logic [DATA_W-1:0] data_mem_WRITE;
    logic [DATA_W-1:0] data_mem_READ;
    logic              busy;

    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_mode, ls_addr, ls_wdata, data_mem_READ,
        output if_rdata, if_done, ls_rdata, ls_done, ls_err,
               mem_addrs, mem_WE, mem_MODE, data_mem_WRITE, busy
    );

    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_mode, ls_addr, ls_wdata, data_mem_READ,
        input  if_rdata, if_done, ls_rdata, ls_done, ls_err,
               mem_addrs, mem_WE, mem_MODE, data_mem_WRITE, busy
    );
endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin pick between fetch and load/store requests.
// Latency: combinational.
// Backpressure: none; the loser simply stays pending.
module rr_pick2
    import bean_pkg::*;
(
    input  logic   req_if,
    input  logic   req_ls,
    input  owner_e last_grant,
    output logic   grant,
    output owner_e owner
);

    always_comb begin
        grant = req_if | req_ls;
        owner = OWN_IF;
        if (req_if && req_ls) begin
            owner = (last_grant == OWN_IF) ? OWN_LS : OWN_IF;
        end else if (req_ls) begin
            owner = OWN_LS;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store with round-robin arbitration.
// Latency: LATENCY+1 cycles grant-to-done (1 cycle for a misaligned load/store).
// Backpressure: requests are levels held until done; one transfer in flight at a time.
module mem_port_arbiter
    import bean_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 2
) (
    input logic              clk,
    input logic              reset,
    mem_port_arbiter_if.slave bus
);

    localparam logic [1:0] S_IDLE   = 2'(ARB_IDLE);
    localparam logic [1:0] S_ACCESS = 2'(ARB_ACCESS);
    localparam logic [1:0] S_DONE   = 2'(ARB_DONE);
    localparam logic [3:0] LAT      = 4'(LATENCY);

    logic [1:0]        state_q;
    logic [3:0]        cnt_q;
    owner_e            last_q;
    owner_e            own_q;
    logic              we_q;
    logic              err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        mode_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] ls_rdata_q;

    logic   pick_vld;
    owner_e pick_own;
    logic   ls_mis;

    rr_pick2 u_pick (
        .req_if     (bus.if_req),
        .req_ls     (bus.ls_req),
        .last_grant (last_q),
        .grant      (pick_vld),
        .owner      (pick_own)
    );

    assign ls_mis = misaligned(bus.ls_mode, bus.ls_addr[1:0]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            last_q     <= OWN_IF;
            own_q      <= OWN_IF;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            mode_q     <= MODE_WORD;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pick_vld) begin
                        last_q <= pick_own;
                        own_q  <= pick_own;
                        if (pick_own == OWN_IF) begin
                            addr_q  <= bus.if_addr;
                            mode_q  <= MODE_WORD;
                            we_q    <= 1'b0;
                            err_q   <= 1'b0;
                            cnt_q   <= LAT;
                            state_q <= S_ACCESS;
                        end else begin
                            addr_q  <= bus.ls_addr;
                            mode_q  <= norm_mode(bus.ls_mode);
                            we_q    <= bus.ls_we;
                            wdata_q <= bus.ls_wdata;
                            err_q   <= ls_mis;
                            // Misaligned accesses never touch memory.
                            if (ls_mis) begin
                                state_q <= S_DONE;
                            end else begin
                                cnt_q   <= LAT;
                                state_q <= S_ACCESS;
                            end
                        end
                    end
                end
                S_ACCESS: begin
                    if (cnt_q == 4'd1) begin
                        cnt_q   <= '0;
                        state_q <= S_DONE;
                        if (own_q == OWN_IF) begin
                            if_rdata_q <= bus.data_mem_READ;
                        end else begin
                            ls_rdata_q <= bus.data_mem_READ;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Strobe is decoded from flops only, so it also drops with the async reset.
    assign bus.mem_WE         = (state_q == S_ACCESS) && (cnt_q == 4'd1) && we_q && (own_q == OWN_LS);
    assign bus.mem_addrs      = addr_q;
    assign bus.mem_MODE       = mode_q;
    assign bus.data_mem_WRITE = wdata_q;
    assign bus.if_rdata       = if_rdata_q;
    assign bus.ls_rdata       = ls_rdata_q;
    assign bus.if_done        = (state_q == S_DONE) && (own_q == OWN_IF);
    assign bus.ls_done        = (state_q == S_DONE) && (own_q == OWN_LS);
    assign bus.ls_err         = (state_q == S_DONE) && (own_q == OWN_LS) && err_q;
    assign bus.busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed transfers at LATENCY=2,
// plus LATENCY=1 and LATENCY=15 instances for completion spacing.
module tb_mem_port_arbiter;
    import bean_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus ();
    mem_port_arbiter_if b1 ();
    mem_port_arbiter_if b15 ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(2))  dut   (.clk(clk), .reset(rst_n), .bus(bus));
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(1))  u_l1  (.clk(clk), .reset(rst_n), .bus(b1));
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(15)) u_l15 (.clk(clk), .reset(rst_n), .bus(b15));

    // Memory model: 0x100 holds 0xDEADBEEF, every other address reads as ~addr.
    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : ~a;
    endfunction

    assign bus.data_mem_READ = mem_model(bus.mem_addrs);
    assign b1.data_mem_READ  = mem_model(b1.mem_addrs);
    assign b15.data_mem_READ = mem_model(b15.mem_addrs);

    typedef struct {
        owner_e      own;
        logic        chk_rd;
        logic [31:0] rdata;
        logic        err;
    } cpl_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  mode;
    } wr_t;

    cpl_t cpl_q[$];
    wr_t  wr_q[$];
    int   checks     = 0;
    int   failures   = 0;
    int   we_cycles  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations on every completion and every write strobe.
    initial begin : monitor
        cpl_t e;
        wr_t  w;
        forever begin
            @(negedge clk);
            if (bus.if_done || bus.ls_done) begin
                chk("done_onehot", 32'(bus.if_done & bus.ls_done), 32'h0);
                if (cpl_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=if%0b_ls%0b required=none", bus.if_done, bus.ls_done);
                end else begin
                    e = cpl_q.pop_front();
                    chk("cpl_owner", 32'(bus.ls_done), 32'(e.own));
                    if (e.own == OWN_IF) begin
                        if (e.chk_rd) chk("if_rdata", bus.if_rdata, e.rdata);
                    end else begin
                        chk("ls_err", 32'(bus.ls_err), 32'(e.err));
                        if (e.chk_rd) chk("ls_rdata", bus.ls_rdata, e.rdata);
                    end
                end
                if (bus.if_done) bus.if_req = 1'b0;
                if (bus.ls_done) bus.ls_req = 1'b0;
            end
            if (bus.mem_WE) begin
                we_cycles++;
                if (wr_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write actual=addr_%h required=none", bus.mem_addrs);
                end else begin
                    w = wr_q.pop_front();
                    chk("wr_addr", bus.mem_addrs, w.addr);
                    chk("wr_data", bus.data_mem_WRITE, w.data);
                    chk("wr_mode", 32'(bus.mem_MODE), 32'(w.mode));
                end
            end
        end
    end

    task automatic push_cpl(input owner_e own, input logic chk_rd, input logic [31:0] rdata, input logic err);
        cpl_t e;
        e.own = own; e.chk_rd = chk_rd; e.rdata = rdata; e.err = err;
        cpl_q.push_back(e);
    endtask

    task automatic push_wr(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] mode);
        wr_t w;
        w.addr = addr; w.data = data; w.mode = mode;
        wr_q.push_back(w);
    endtask

    task automatic if_issue(input logic [31:0] addr);
        bus.if_addr = addr;
        bus.if_req  = 1'b1;
    endtask

    task automatic ls_issue(input logic we, input logic [1:0] mode, input logic [31:0] addr, input logic [31:0] wdata);
        bus.ls_we    = we;
        bus.ls_mode  = mode;
        bus.ls_addr  = addr;
        bus.ls_wdata = wdata;
        bus.ls_req   = 1'b1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((cpl_q.size() != 0 || bus.busy || bus.if_req || bus.ls_req) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({"drain_", name}, 32'(n >= 200), 32'h0);
    endtask

    initial begin : stim
        int w0;
        int d1a, d1b, d15a, d15b;
        bus.if_req = 0; bus.if_addr = 0; bus.ls_req = 0; bus.ls_we = 0;
        bus.ls_mode = 0; bus.ls_addr = 0; bus.ls_wdata = 0;
        b1.if_req = 0; b1.if_addr = 0; b1.ls_req = 0; b1.ls_we = 0;
        b1.ls_mode = 0; b1.ls_addr = 0; b1.ls_wdata = 0;
        b15.if_req = 0; b15.if_addr = 0; b15.ls_req = 0; b15.ls_we = 0;
        b15.ls_mode = 0; b15.ls_addr = 0; b15.ls_wdata = 0;

        #1 rst_n = 1'b0;
        #11;
        chk("rst_mem_addrs", bus.mem_addrs, 32'h0);
        chk("rst_mem_WE", 32'(bus.mem_WE), 32'h0);
        chk("rst_mem_MODE", 32'(bus.mem_MODE), 32'h2);
        chk("rst_wdata", bus.data_mem_WRITE, 32'h0);
        chk("rst_if_rdata", bus.if_rdata, 32'h0);
        chk("rst_ls_rdata", bus.ls_rdata, 32'h0);
        chk("rst_dones", {29'b0, bus.if_done, bus.ls_done, bus.ls_err}, 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Simultaneous pair straight after reset: LS wins, then IF.
        push_cpl(OWN_LS, 1'b1, 32'hFFFFFCFF, 1'b0);
        push_cpl(OWN_IF, 1'b1, 32'hFFFFFEFB, 1'b0);
        ls_issue(1'b0, MODE_WORD, 32'h300, 32'h0);
        if_issue(32'h104);
        @(posedge clk);
        @(negedge clk);
        chk("pair1_first_addr", bus.mem_addrs, 32'h300);
        drain("pair1");

        // Fetch only, detailed timing.
        push_cpl(OWN_IF, 1'b1, 32'hDEADBEEF, 1'b0);
        if_issue(32'h100);
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("fetch_addr", bus.mem_addrs, 32'h100);
            chk("fetch_we", 32'(bus.mem_WE), 32'h0);
            chk("fetch_mode", 32'(bus.mem_MODE), 32'h2);
            chk("fetch_busy", 32'(bus.busy), 32'h1);
        end
        @(negedge clk);
        chk("fetch_done_cyc", 32'(bus.if_done), 32'h1);
        @(negedge clk);
        chk("fetch_busy_fall", 32'(bus.busy), 32'h0);
        drain("fetch");

        // Aligned word store: strobe only in the last ACCESS cycle.
        w0 = we_cycles;
        push_wr(32'h204, 32'h12345678, MODE_WORD);
        push_cpl(OWN_LS, 1'b0, 32'h0, 1'b0);
        ls_issue(1'b1, MODE_WORD, 32'h204, 32'h12345678);
        @(posedge clk);
        @(negedge clk);
        chk("store_we_c1", 32'(bus.mem_WE), 32'h0);
        @(negedge clk);
        chk("store_we_c2", 32'(bus.mem_WE), 32'h1);
        @(negedge clk);
        chk("store_done_cyc", 32'(bus.ls_done), 32'h1);
        drain("store");
        chk("store_we_cycles", 32'(we_cycles - w0), 32'h1);

        // Second pair: last grant was LS, so IF goes first.
        push_cpl(OWN_IF, 1'b1, 32'hFFFFFEF7, 1'b0);
        push_cpl(OWN_LS, 1'b1, 32'hFFFFFCF3, 1'b0);
        ls_issue(1'b0, MODE_WORD, 32'h30C, 32'h0);
        if_issue(32'h108);
        drain("pair2");

        // Misaligned half store: immediate error, no strobe, load data kept.
        w0 = we_cycles;
        push_cpl(OWN_LS, 1'b1, 32'hFFFFFCF3, 1'b1);
        ls_issue(1'b1, MODE_HALF, 32'h203, 32'h5555AAAA);
        @(posedge clk);
        @(negedge clk);
        chk("mis_done", {30'b0, bus.ls_done, bus.ls_err}, 32'h3);
        chk("mis_we", 32'(bus.mem_WE), 32'h0);
        drain("mis");
        chk("mis_we_cycles", 32'(we_cycles - w0), 32'h0);

        // Byte store at an odd address is legal; mode 11 loads as a word.
        push_wr(32'h207, 32'h000000AB, MODE_BYTE);
        push_cpl(OWN_LS, 1'b0, 32'h0, 1'b0);
        ls_issue(1'b1, MODE_BYTE, 32'h207, 32'h000000AB);
        drain("byte");
        push_cpl(OWN_LS, 1'b1, 32'hFFFFFCEF, 1'b0);
        ls_issue(1'b0, 2'b11, 32'h310, 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("mode11_mode", 32'(bus.mem_MODE), 32'h2);
        drain("mode11");

        // Reset during the strobe cycle of a store.
        push_wr(32'h208, 32'hCAFEF00D, MODE_WORD);
        ls_issue(1'b1, MODE_WORD, 32'h208, 32'hCAFEF00D);
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_we", 32'(bus.mem_WE), 32'h0);
        chk("arst_busy", 32'(bus.busy), 32'h0);
        chk("arst_mem_addrs", bus.mem_addrs, 32'h0);
        bus.ls_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("arst_ls_rdata", bus.ls_rdata, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        push_cpl(OWN_IF, 1'b1, 32'hDEADBEEF, 1'b0);
        if_issue(32'h100);
        drain("post_rst");

        // LATENCY=1 and 15: first done and back-to-back period.
        d1a = 0; d1b = 0; d15a = 0; d15b = 0;
        b1.if_addr  = 32'h40;
        b15.if_addr = 32'h80;
        b1.if_req   = 1'b1;
        b15.if_req  = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (b1.if_done) begin
                if (d1a == 0) d1a = k; else if (d1b == 0) d1b = k;
            end
            if (b15.if_done) begin
                if (d15a == 0) d15a = k; else if (d15b == 0) d15b = k;
            end
        end
        b1.if_req  = 1'b0;
        b15.if_req = 1'b0;
        chk("l1_first_done", 32'(d1a), 32'd2);
        chk("l1_period", 32'(d1b - d1a), 32'd3);
        chk("l15_first_done", 32'(d15a), 32'd16);
        chk("l15_period", 32'(d15b - d15a), 32'd17);
        chk("l1_rdata", b1.if_rdata, 32'hFFFFFFBF);
        chk("l15_rdata", b15.if_rdata, 32'hFFFFFF7F);

        repeat (3) @(negedge clk);
        chk("cpl_q_empty", 32'(cpl_q.size()), 32'h0);
        chk("wr_q_empty", 32'(wr_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single memory port of the BEAN-1 core between the instruction-fetch requester and the load/store requester. It sits between the control/datapath pair and the memory, and drives `mem_addrs`, `mem_WE`, `mem_MODE` and `data_mem_WRITE`. Each access is sequenced through a fixed-latency access window, with round-robin arbitration on conflicts and alignment checking on load/store.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `LATENCY`, 2, memory access cycles per transfer; legal range 1..15
- `clk`  in  1  clock; all flops update on the rising edge
- `reset`  in  1  asynchronous, active-low reset (0 = reset)
- `if_req`  in  1  fetch request; level, held until `if_done`
- `if_addr`  in  ADDR_W  fetch address
- `if_rdata`  out  DATA_W  fetched word; registered
- `if_done`  out  1  one-cycle completion pulse
- `ls_req`  in  1  load/store request; level, held until `ls_done`
- `ls_we`  in  1  1 = store, 0 = load
- `ls_mode`  in  2  access size: 00 byte, 01 half, 10 word (11 treated as word)
- `ls_addr`  in  ADDR_W  load/store address
- `ls_wdata`  in  DATA_W  store data
- `ls_rdata`  out  DATA_W  load data; registered
- `ls_done`  out  1  one-cycle completion pulse
- `ls_err`  out  1  misalignment flag; valid only with `ls_done`
- `mem_addrs`  out  ADDR_W  memory address
- `mem_WE`  out  1  memory write strobe
- `mem_MODE`  out  2  memory access size
- `data_mem_WRITE`  out  DATA_W  memory write data
- `data_mem_READ`  in  DATA_W  memory read data
- `busy`  out  1  high in any state except IDLE

## Operation
- States:
  - IDLE: samples requests.
  - ACCESS: memory window; counter runs `LATENCY` down to 1.
  - DONE: one cycle; pulses the completion signal for the granted port.
- IDLE transitions:
  - One request → grant that port.
  - Both requests → grant the port not in `last_grant`. `last_grant` resets to IF, so the first conflict after reset goes to LS.
  - `last_grant` updates on every grant.
- Grant latches address, mode, we, wdata and owner. Memory outputs come only from these latched values and stay stable for the whole ACCESS window.
- Fetch grants are always word-sized reads: `mem_MODE`=10, `mem_WE`=0.
- LS misalignment: half with `addr[0]`=1, or word with `addr[1:0]`≠0.
  - A misaligned grant goes IDLE→DONE directly, with no ACCESS and no `mem_WE`.
  - `ls_done`=1 and `ls_err`=1 for that cycle; `ls_rdata` is unchanged.
- `mem_WE` is asserted only in the final ACCESS cycle (counter=1), and only for an aligned LS store.
- Read data: `data_mem_READ` is captured on the final ACCESS edge into `if_rdata` or `ls_rdata`. The value is held until that port's next completion.
- A requester that drops `req` mid-access does not abort the transfer: it completes and `done` still pulses.
- DONE → IDLE always. Requests are re-arbitrated in IDLE, so there is no back-to-back grant from DONE.

## Timing
- Reset values:
  - State IDLE, counter 0, `last_grant`=IF.
  - `mem_addrs`=0, `mem_WE`=0, `mem_MODE`=10, `data_mem_WRITE`=0.
  - `if_rdata`=0, `ls_rdata`=0, all done/err flags 0, `busy`=0.
- Asserting `reset` mid-access forces these values immediately, without waiting for `clk`. `mem_WE` drops asynchronously and the in-flight transfer is lost with no `done`.
- Aligned access:
  - `req` is sampled high in IDLE at edge N.
  - ACCESS occupies cycles N+1 .. N+LATENCY.
  - DONE occupies cycle N+LATENCY+1.
  - Latency from grant edge to done is LATENCY+1 cycles.
  - Peak throughput is one transfer per LATENCY+2 cycles.
- Misaligned access: done and err are high in cycle N+1.
- `done` and `err` are registered outputs, decoded from state.
- `busy` rises in the cycle after the grant edge and falls in the cycle after DONE.

## Structure
- Shared package `bean_pkg` holds:
  - Mode constants: `MODE_BYTE`=2'b00, `MODE_HALF`=2'b01, `MODE_WORD`=2'b10.
  - Arbiter state enum: IDLE, ACCESS, DONE.
  - Owner encoding: IF=0, LS=1.
- One sub-module, `rr_pick2`: a combinational two-way round-robin choice from (`req_if`, `req_ls`, `last_grant`) to `grant`/`owner`.
- The FSM, latency counter, latch registers and alignment check stay in the top module.

## Test plan
- Fetch only, `LATENCY`=2, `if_addr`=0x100, memory returns 0xDEADBEEF:
  - `mem_addrs`=0x100 for 2 cycles with `mem_WE`=0.
  - `if_done` pulses 3 cycles after the grant edge with `if_rdata`=0xDEADBEEF.
- `if_req` and `ls_req` rise together right after reset:
  - LS is granted first; IF is granted at the next IDLE.
  - A second simultaneous pair alternates (IF first this time).
- LS store, `ls_mode`=10, addr 0x204, data 0x12345678:
  - `mem_WE`=1 for exactly one cycle, on the final ACCESS cycle.
  - `data_mem_WRITE`=0x12345678 and `mem_MODE`=10 during that cycle.
- LS half store at addr 0x203:
  - No `mem_WE` ever.
  - `ls_done`=`ls_err`=1 one cycle after the grant; `ls_rdata` unchanged.
- `reset` driven to 0 during ACCESS of a store:
  - `mem_WE` and `busy` go 0 immediately and no `done` pulses.
  - After release, a new fetch completes normally.
- `LATENCY`=1 and `LATENCY`=15 builds: fetch-done spacing is 2 and 16 cycles respectively, and back-to-back requests see a 3- and 17-cycle period.
